// File: rtl/mem_access_unit_if.sv
// Request/response bundle between the execute-side sequencer and mem_access_unit.
// The master drives the request and branch controls; the slave returns status and load data.
interface mem_access_unit_if #(
   parameter int WORD = 64
);
   logic            start;
   logic            uncondbranch;
   logic            branch;
   logic            zero;
   logic            mem_read;
   logic            mem_write;
   logic [1:0]      size;
   logic            sign_ext;
   logic [WORD-1:0] address;
   logic [WORD-1:0] write_data;
   logic            busy;
   logic            done;
   logic            pc_src;
   logic [WORD-1:0] read_data;
   logic            misalign_fault;

   modport master (
      output start, uncondbranch, branch, zero, mem_read, mem_write,
             size, sign_ext, address, write_data,
      input  busy, done, pc_src, read_data, misalign_fault
   );

   modport slave (
      input  start, uncondbranch, branch, zero, mem_read, mem_write,
             size, sign_ext, address, write_data,
      output busy, done, pc_src, read_data, misalign_fault
   );
endinterface

// File: rtl/mem_access_unit.sv
// Multi-cycle LEGv8 memory stage: little-endian byte-addressed store with a fixed wait latency.
// Optional macro MEM_ALIGN_CHECK_EN turns misaligned accesses into faults instead of truncating them.
module mem_access_unit #(
   parameter int WORD    = 64,
   parameter int DEPTH   = 256,
   parameter int LATENCY = 2
) (
   input  logic             clk,
   input  logic             reset,
   mem_access_unit_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

   state_t          r_state;
   state_t          w_state_next;
   logic [CW-1:0]   r_cnt;
   logic            r_ub, r_br, r_zero, r_rd, r_wr, r_sext;
   logic [1:0]      r_size;
   logic [AW+2:0]   r_addr;
   logic [WORD-1:0] r_wdata;
   logic [WORD-1:0] r_read_data;

   logic            w_accept, w_commit, w_done, w_misalign;
   logic [2:0]      w_keep, w_off;
   logic [7:0]      w_size_lanes, w_lane_en;
   logic [AW-1:0]   w_idx;
   logic [WORD-1:0] w_wdata_sh, w_rd_word, w_rd_sh, w_load_val;
   logic            w_unused;

   assign w_unused = ^bus.address[WORD-1:AW+3];

   assign w_accept = bus.start && (r_state == S_IDLE || r_state == S_DONE);
   assign w_commit = (r_state == S_WAIT) && (r_cnt == '0);
   assign w_done   = (r_state == S_DONE);

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (bus.start) w_state_next = S_WAIT;
         S_WAIT:  if (r_cnt == '0) w_state_next = S_DONE;
         S_DONE:  w_state_next = bus.start ? S_WAIT : S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   // w_keep selects the offset bits that survive for this size, which is what
   // makes natural alignment by truncation and the misalignment test the same mask.
   always_comb begin
      w_keep       = 3'b111;
      w_size_lanes = 8'h01;
      case (r_size)
         2'b00: begin w_keep = 3'b111; w_size_lanes = 8'h01; end
         2'b01: begin w_keep = 3'b110; w_size_lanes = 8'h03; end
         2'b10: begin w_keep = 3'b100; w_size_lanes = 8'h0F; end
         default: begin w_keep = 3'b000; w_size_lanes = 8'hFF; end
      endcase
   end

   assign w_off      = r_addr[2:0] & w_keep;
   assign w_idx      = r_addr[AW+2:3];
   assign w_lane_en  = w_size_lanes << w_off;
   assign w_wdata_sh = r_wdata << {w_off, 3'b000};
   assign w_rd_sh    = w_rd_word >> {w_off, 3'b000};

`ifdef MEM_ALIGN_CHECK_EN
   assign w_misalign = |(r_addr[2:0] & ~w_keep);
`else
   assign w_misalign = 1'b0;
`endif

   always_comb begin
      w_load_val = w_rd_sh;
      case (r_size)
         2'b00:   w_load_val = {{56{r_sext & w_rd_sh[7]}},  w_rd_sh[7:0]};
         2'b01:   w_load_val = {{48{r_sext & w_rd_sh[15]}}, w_rd_sh[15:0]};
         2'b10:   w_load_val = {{32{r_sext & w_rd_sh[31]}}, w_rd_sh[31:0]};
         default: w_load_val = w_rd_sh;
      endcase
   end

   // One byte-wide bank per lane; the read is taken before the same-edge write.
   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_lane
         logic [7:0] r_bank [DEPTH];
         always_ff @(posedge clk) begin
            if (!reset && w_commit && r_wr && !w_misalign && w_lane_en[gi])
               r_bank[w_idx] <= w_wdata_sh[gi*8 +: 8];
         end
         assign w_rd_word[gi*8 +: 8] = r_bank[w_idx];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_ub        <= 1'b0;
         r_br        <= 1'b0;
         r_zero      <= 1'b0;
         r_rd        <= 1'b0;
         r_wr        <= 1'b0;
         r_sext      <= 1'b0;
         r_size      <= 2'b00;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_read_data <= '0;
      end else begin
         r_state <= w_state_next;
         if (w_accept) begin
            r_cnt   <= CNT_INIT;
            r_ub    <= bus.uncondbranch;
            r_br    <= bus.branch;
            r_zero  <= bus.zero;
            r_rd    <= bus.mem_read;
            r_wr    <= bus.mem_write;
            r_sext  <= bus.sign_ext;
            r_size  <= bus.size;
            r_addr  <= bus.address[AW+2:0];
            r_wdata <= bus.write_data;
         end else if (r_state == S_WAIT && r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
         end
         if (w_commit && r_rd && !w_misalign)
            r_read_data <= w_load_val;
      end
   end

`ifdef MEM_ALIGN_CHECK_EN
   logic r_fault;
   always_ff @(posedge clk) begin
      if (reset)
         r_fault <= 1'b0;
      else if (w_commit)
         r_fault <= w_misalign;
   end
   assign bus.misalign_fault = w_done & r_fault;
`else
   assign bus.misalign_fault = 1'b0;
`endif

   assign bus.busy      = (r_state == S_WAIT);
   assign bus.done      = w_done;
   assign bus.pc_src    = w_done & (r_ub | (r_br & r_zero));
   assign bus.read_data = r_read_data;
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Parametrised, multi-cycle successor to the LEGv8 memory stage. Accepts one load/store per request, accesses an internal byte-addressed, little-endian data store with a configurable wait latency, supports byte/half/word/doubleword sizes with optional sign extension, and resolves the branch decision (`pc_src`) in step with completion. Sits between execute and write-back; `busy` stalls the PC/control sequencer and `done` qualifies `read_data` and `pc_src`.

## Interface
Parameters:
- `WORD`, 64: data/address width in bits; must be 64.
- `DEPTH`, 256: storage depth in doublewords; power of two, ≥ 2.
- `LATENCY`, 2: cycles spent in WAIT per access; ≥ 1.

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  request strobe.
- `uncondbranch`, `branch`, `zero`  in  1 each  branch controls.
- `mem_read`, `mem_write`  in  1 each  access type.
- `size`  in  2  00 byte, 01 half, 10 word (32b), 11 doubleword.
- `sign_ext`  in  1  sign-extend loads narrower than 64b.
- `address`, `write_data`  in  WORD.
- `busy`  out  1  access in progress.
- `done`  out  1  one-cycle completion pulse.
- `pc_src`  out  1  branch taken; valid only while `done`.
- `read_data`  out  WORD  load result.
- `misalign_fault`  out  1  alignment error; valid only while `done`.

## Operation
- FSM states: IDLE, WAIT, DONE. `busy` = (state==WAIT); `done` = (state==DONE).
- Accept: in IDLE or DONE with `start`=1 → capture all request inputs, load counter with LATENCY−1, go to WAIT. Back-to-back requests are legal from DONE.
- `start` while in WAIT is ignored; no queuing.
- WAIT: counter==0 → DONE, else decrement.
- DONE: without new `start` → IDLE.
- Memory action occurs on the WAIT→DONE edge using captured values:
  - Word index = `address[$clog2(DEPTH)+2:3]`; upper address bits ignored (aliasing wrap-around).
  - Byte offset = `address[2:0]`. Store writes only the 1/2/4/8 addressed byte lanes from the low bytes of `write_data`.
  - Load extracts the addressed bytes, right-justified, zero- or sign-extended per `sign_ext`; `sign_ext` ignored for size 11.
  - Both `mem_read` and `mem_write`: write performed; `read_data` returns pre-write contents.
  - Neither set: no memory action; `read_data` unchanged.
- `pc_src` = `done` & (captured `uncondbranch` | (captured `branch` & captured `zero`)).
- `read_data` holds its value until the next completing load.
- Accesses crossing a doubleword boundary (offset+bytes > 8): see Configuration.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `pc_src`=0, `read_data`=0, `misalign_fault`=0. Memory contents are not cleared.
- Accept at edge k → `busy` high cycles k..k+LATENCY−1 → `done` high for the one cycle after edge k+LATENCY.
- Throughput: one access per LATENCY+1 cycles.
- Reset mid-WAIT aborts the access; a pending store is not committed. Reset overrides a simultaneous `start`.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined: an access whose address is not a multiple of its size completes normally in time, performs no memory action, leaves `read_data` unchanged, and asserts `misalign_fault` with `done`.
- Not defined: `misalign_fault` is tied 0; address bits below the access size are forced to zero (natural alignment by truncation) and the access proceeds.

## Test plan
- Reset, then STUR size 11 of 0x0123456789ABCDEF to 0x40, then LDUR 0x40 → `busy` for 2 cycles each, `done` 1 cycle, `read_data`=0x0123456789ABCDEF.
- STURB 0x80 to 0x43, then LDURB 0x43 with `sign_ext`=1 → 0xFFFFFFFFFFFFFF80; with `sign_ext`=0 → 0x80; LDUR 0x40 → 0x0123456780ABCDEF.
- `branch`=1, `zero`=1 request → `pc_src`=1 only in the `done` cycle; `uncondbranch`=0, `branch`=1, `zero`=0 → `pc_src`=0.
- `start` during WAIT and back-to-back `start` in DONE → first ignored; second accepted, next `done` exactly LATENCY+1 cycles after the previous one.
- `reset` asserted mid-WAIT of store 0xFF.. to 0x08 → outputs return to reset values next cycle; subsequent load of 0x08 returns prior contents.
- Half load at 0x41: with `MEM_ALIGN_CHECK_EN` → `misalign_fault`=1, `read_data` unchanged; without → reads 0x40, `misalign_fault`=0.
